// File: rtl/riscv_pkg.sv
`timescale 1ns/1ps
// Shared types for the riscv data-memory path: access size, arbiter states,
// and the byte-count helper used by the byte sequencer.
package riscv_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        LAST,
        ACK
    } arb_state_t;

    // Raw size code to enum; the reserved code 11 is handled as a word.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // Number of byte cycles for one access.
    function automatic logic [2:0] nbytes(input mem_size_t sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
`timescale 1ns/1ps
// Two-requester round-robin pick. `last` = 1 means dbg was granted last,
// so on a tie the cpu wins; `last` = 0 hands a tie to dbg.
module dmem_rr_pick
    import riscv_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last,
    output logic grant,
    output logic grant_dbg
);

    // Grant whichever requester is alone, or the one not served last on a tie.
    always_comb begin
        grant     = cpu_req | dbg_req;
        grant_dbg = dbg_req & (~cpu_req | ~last);
    end

endmodule

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Byte-serial sequencer and cpu/debug arbiter for the single byte port of
// the data memory. Accesses of 1/2/4 bytes are split into little-endian byte
// cycles; load bytes arrive one cycle after their strobe and are assembled
// into rdata.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_size,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [1:0]        dbg_size,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_next;

    logic              pick_valid;
    logic              pick_dbg;
    logic              last;
    logic              sel_dbg;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    mem_size_t         lat_size;
    logic [31:0]       lat_wdata;
    logic [1:0]        k;
    logic [1:0]        k_inc;
    logic [1:0]        k_dec;
    logic              last_byte;

    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    dmem_rr_pick u_pick (
        .cpu_req   (cpu_req),
        .dbg_req   (dbg_req),
        .last      (last),
        .grant     (pick_valid),
        .grant_dbg (pick_dbg)
    );

    assign k_inc     = k + 2'd1;
    assign k_dec     = k - 2'd1;
    assign last_byte = ({1'b0, k} == (nbytes(lat_size) - 3'd1));
    assign req_addr  = pick_dbg ? dbg_addr  : cpu_addr;
    assign req_wdata = pick_dbg ? dbg_wdata : cpu_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state: grant from IDLE, walk the bytes, then one ack cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_valid) state_next = XFER;
            XFER: if (last_byte)  state_next = lat_we ? ACK : LAST;
            LAST: state_next = ACK;
            ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ack decode: one pulse to whichever requester owns the transfer.
    always_comb begin
        cpu_ack = (state == ACK) & ~sel_dbg;
        dbg_ack = (state == ACK) &  sel_dbg;
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

    // Datapath: latch the granted request, drive the registered byte port
    // one byte ahead of the counter, and assemble returning load bytes.
    // Byte k's read data is present while the counter shows k+1 (or in LAST
    // for the final byte), hence the k-1 capture index in XFER.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last      <= 1'b1;
            sel_dbg   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= SZ_B;
            lat_wdata <= '0;
            k         <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel_dbg   <= pick_dbg;
                        lat_we    <= pick_dbg ? dbg_we : cpu_we;
                        lat_addr  <= req_addr;
                        lat_size  <= decode_size(pick_dbg ? dbg_size : cpu_size);
                        lat_wdata <= req_wdata;
                        k         <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_dbg ? dbg_we : cpu_we;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata[7:0];
                    end
                end
                XFER: begin
                    if (!lat_we && (k != 2'd0)) begin
                        if (k == 2'd1) rdata <= {24'h0, mem_rdata};
                        else           rdata[{k_dec, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (last_byte) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        k         <= k_inc;
                        mem_addr  <= lat_addr + ADDR_W'(k_inc);
                        mem_wdata <= lat_wdata[{k_inc, 3'b000} +: 8];
                    end
                end
                LAST: begin
                    if (k == 2'd0) rdata <= {24'h0, mem_rdata};
                    else           rdata[{k, 3'b000} +: 8] <= mem_rdata;
                end
                ACK: begin
                    last <= sel_dbg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Testbench for dmem_arbiter: byte-wide memory device model plus a
// byte-array reference of what memory and load results should be.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
    logic [1:0]  cpu_size, dbg_size;
    logic        cpu_ack, cpu_stall, dbg_ack;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]  dev_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] wlog [$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_size(dbg_size),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte memory device: synchronous write, read data one cycle after strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                dev_mem[mem_addr] = mem_wdata;
                wlog.push_back(mem_addr);
            end else begin
                mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : 8'h00;
            end
        end
    end

    function automatic logic [7:0] dev_get(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic int exp_latency(input bit we, input logic [1:0] s);
        return we ? size_bytes(s) + 1 : size_bytes(s) + 2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_get(a + 32'(i));
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        dev_mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Issue one access on a single port and observe it for a fixed window.
    task automatic run_access(input bit dbg, input bit we, input logic [31:0] addr,
                              input logic [1:0] size, input logic [31:0] wd,
                              output int lat, output int nacks, output int nother,
                              output logic [31:0] rd, output logic [15:0] strace);
        lat = 0; nacks = 0; nother = 0; rd = '0; strace = '0;
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_size = size; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size; cpu_wdata = wd;
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            strace[i] = cpu_stall;
            if (dbg ? dbg_ack : cpu_ack) begin
                nacks++;
                if (lat == 0) begin
                    lat = i;
                    rd  = rdata;
                end
                if (dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
            end
            if (dbg ? cpu_ack : dbg_ack) nother++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_req = 1'b1;
        #3;
        checks++;
        if ({cpu_ack, dbg_ack, mem_en, mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {cpu_ack, dbg_ack, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 8'h00) begin
            errors++; $display("FAIL reset_bus got addr %h wdata %h exp 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h exp 00000000", rdata);
        end
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall_hi got %b exp 1", cpu_stall);
        end
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall_lo got %b exp 0", cpu_stall);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load_word();
        int lat, nacks, nother;
        logic [31:0] rd;
        logic [15:0] st;
        run_access(1'b0, 1'b1, 32'd4, 2'b10, 32'h0F0F0F0D, lat, nacks, nother, rd, st);
        for (int i = 0; i < 4; i++) ref_mem[32'd4 + 32'(i)] = (i == 0) ? 8'h0D : 8'h0F;
        checks++;
        if (lat !== 5 || nacks !== 1) begin
            errors++; $display("FAIL sw_latency got lat %0d acks %0d exp 5/1", lat, nacks);
        end
        checks++;
        if ({dev_get(4), dev_get(5), dev_get(6), dev_get(7)} !== 32'h0D0F0F0F) begin
            errors++; $display("FAIL sw_bytes got %h%h%h%h exp 0D0F0F0F",
                               dev_get(4), dev_get(5), dev_get(6), dev_get(7));
        end
        run_access(1'b0, 1'b0, 32'd4, 2'b10, 32'h0, lat, nacks, nother, rd, st);
        checks++;
        if (lat !== 6 || nacks !== 1) begin
            errors++; $display("FAIL lw_latency got lat %0d acks %0d exp 6/1", lat, nacks);
        end
        checks++;
        if (rd !== 32'h0F0F0F0D) begin
            errors++; $display("FAIL lw_data got %h exp 0F0F0F0D", rd);
        end
    endtask

    task automatic test_load_half();
        int lat, nacks, nother;
        logic [31:0] rd;
        logic [15:0] st;
        preload(32'd16, 8'h11);
        preload(32'd17, 8'hFF);
        run_access(1'b0, 1'b0, 32'd16, 2'b01, 32'h0, lat, nacks, nother, rd, st);
        checks++;
        if (rd !== 32'h0000FF11 || lat !== 4) begin
            errors++; $display("FAIL lh_data got %h lat %0d exp 0000FF11 lat 4", rd, lat);
        end
        checks++;
        if (st !== 16'h000E) begin
            errors++; $display("FAIL lh_stall got %h exp 000e", st);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit          dbg = 1'($urandom_range(0, 1));
            bit          we  = 1'($urandom_range(0, 1));
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            logic [31:0] a   = 32'h100 + 32'($urandom_range(0, 31));
            logic [31:0] wd  = $urandom;
            int          n   = size_bytes(sz);
            int          el  = exp_latency(we, sz);
            logic [15:0] est = dbg ? 16'h0 : 16'((1 << el) - 2);
            int lat, nacks, nother;
            logic [31:0] rd, expv, got;
            logic [15:0] st;
            expv = ref_load(a, n);
            run_access(dbg, we, a, sz, wd, lat, nacks, nother, rd, st);
            checks++;
            if (lat !== el || nacks !== 1 || nother !== 0) begin
                errors++; $display("FAIL rnd_ack t%0d got lat %0d acks %0d other %0d exp %0d/1/0",
                                   t, lat, nacks, nother, el);
            end
            checks++;
            if (st !== est) begin
                errors++; $display("FAIL rnd_stall t%0d got %h exp %h", t, st, est);
            end
            if (we) begin
                expv = '0;
                got  = '0;
                for (int i = 0; i < n; i++) begin
                    ref_mem[a + 32'(i)] = wd[8*i +: 8];
                    expv[8*i +: 8] = wd[8*i +: 8];
                    got[8*i +: 8]  = dev_get(a + 32'(i));
                end
                checks++;
                if (got !== expv) begin
                    errors++; $display("FAIL rnd_store t%0d @%h got %h exp %h", t, a, got, expv);
                end
            end else begin
                checks++;
                if (rd !== expv) begin
                    errors++; $display("FAIL rnd_load t%0d @%h size %0d got %h exp %h", t, a, sz, rd, expv);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int lat, nacks, nother;
        logic [31:0] rd, e;
        logic [15:0] st;
        wlog.delete();
        run_access(1'b1, 1'b1, 32'hFFFFFFFE, 2'b10, 32'hA1B2C3D4, lat, nacks, nother, rd, st);
        checks++;
        if (lat !== 5 || nacks !== 1 || nother !== 0) begin
            errors++; $display("FAIL wrap_ack got lat %0d acks %0d other %0d exp 5/1/0", lat, nacks, nother);
        end
        checks++;
        if (wlog.size() !== 4) begin
            errors++; $display("FAIL wrap_count got %0d exp 4", wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = 32'hFFFFFFFE + 32'(i);
                checks++;
                if (wlog[i] !== e) begin
                    errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, wlog[i], e);
                end
            end
        end
        checks++;
        if ({dev_get(32'hFFFFFFFE), dev_get(32'hFFFFFFFF), dev_get(0), dev_get(1)} !== 32'hD4C3B2A1) begin
            errors++; $display("FAIL wrap_bytes got %h%h%h%h exp D4C3B2A1",
                               dev_get(32'hFFFFFFFE), dev_get(32'hFFFFFFFF), dev_get(0), dev_get(1));
        end
    endtask

    task automatic test_round_robin();
        int who [$];
        int cyc [$];
        int both = 0;
        apply_reset();
        preload(32'h300, 8'hC1);
        preload(32'h304, 8'hD2);
        cpu_we = 1'b0; cpu_addr = 32'h300; cpu_size = 2'b00;
        dbg_we = 1'b0; dbg_addr = 32'h304; dbg_size = 2'b00;
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cpu_ack && dbg_ack) both++;
            if (cpu_ack || dbg_ack) begin
                who.push_back(dbg_ack ? 1 : 0);
                cyc.push_back(i);
                checks++;
                if (rdata !== (dbg_ack ? 32'h000000D2 : 32'h000000C1)) begin
                    errors++; $display("FAIL rr_data%0d got %h exp %h", who.size(), rdata,
                                       dbg_ack ? 32'h000000D2 : 32'h000000C1);
                end
                if (who.size() == 6) begin
                    cpu_req = 1'b0;
                    dbg_req = 1'b0;
                end
            end
        end
        checks++;
        if (who.size() !== 6 || both !== 0) begin
            errors++; $display("FAIL rr_count got %0d acks %0d overlaps exp 6/0", who.size(), both);
        end
        for (int j = 0; j < who.size(); j++) begin
            checks++;
            if (who[j] !== (j % 2) || cyc[j] !== 3 + 4 * j) begin
                errors++; $display("FAIL rr_order%0d got who %0d cycle %0d exp who %0d cycle %0d",
                                   j, who[j], cyc[j], j % 2, 3 + 4 * j);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nacks, nother, acks_seen, first_who;
        logic [31:0] rd;
        logic [15:0] st;
        run_access(1'b0, 1'b1, 32'h400, 2'b00, 32'h77, lat, nacks, nother, rd, st);
        wlog.delete();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h410; cpu_size = 2'b10; cpu_wdata = 32'h11223344;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rstmid_bus got en %b we %b addr %h exp 0/0/0", mem_en, mem_we, mem_addr);
        end
        acks_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) acks_seen++;
            if (i == 2) rst = 1'b1;
        end
        checks++;
        if (acks_seen !== 0) begin
            errors++; $display("FAIL rstmid_ack got %0d acks exp 0", acks_seen);
        end
        checks++;
        if (wlog.size() !== 1 || dev_get(32'h410) !== 8'h44 || dev_get(32'h411) === 8'h33) begin
            errors++; $display("FAIL rstmid_writes got %0d writes byte0 %h exp 1 write byte0 44",
                               wlog.size(), dev_get(32'h410));
        end
        ref_mem[32'h410] = 8'h44;
        cpu_we = 1'b0; cpu_addr = 32'h300; cpu_size = 2'b00;
        dbg_we = 1'b0; dbg_addr = 32'h304; dbg_size = 2'b00;
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        first_who = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (first_who < 0 && (cpu_ack || dbg_ack)) begin
                first_who = dbg_ack ? 1 : 0;
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        checks++;
        if (first_who !== 0) begin
            errors++; $display("FAIL rstmid_tie got %0d exp 0 (cpu)", first_who);
        end
    endtask

    task automatic test_drop_req();
        int lat = 0, nacks = 0;
        logic [31:0] rd = '0;
        preload(32'h500, 8'h5A);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; cpu_size = 2'b00;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_addr = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                nacks++;
                if (lat == 0) begin
                    lat = i;
                    rd  = rdata;
                end
            end
        end
        checks++;
        if (nacks !== 1 || lat !== 3) begin
            errors++; $display("FAIL drop_ack got %0d acks lat %0d exp 1/3", nacks, lat);
        end
        checks++;
        if (rd !== 32'h0000005A) begin
            errors++; $display("FAIL drop_data got %h exp 0000005a", rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_size = '0; dbg_wdata = '0;
        for (int a = 32'h100; a < 32'h128; a++) preload(32'(a), 8'($urandom));
        test_reset();
        test_store_load_word();
        test_load_half();
        test_random();
        test_wrap();
        test_round_robin();
        test_reset_mid();
        test_drop_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the byte-wide data memory of the `riscv` core. It shares the single byte port of `mem1` between the pipeline MEM stage and a debug/bench access port. It serialises 8/16/32-bit accesses into little-endian byte cycles and stalls the pipeline while its access is pending. The debug port replaces hierarchical peeks of `mem1.mem` for result checking.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of data memory

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `cpu_req`  in  1  pipeline access request
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  byte address
- `cpu_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `cpu_wdata`  in  32  store data, low bytes used
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_size`, `dbg_wdata`, `dbg_ack`  same as cpu_* for the debug requester
- `rdata`  out  32  assembled load data, valid in the ack cycle
- `mem_en`  out  1  byte access strobe
- `mem_we`  out  1  byte write enable
- `mem_addr`  out  ADDR_W  byte address
- `mem_wdata`  out  8  write byte
- `mem_rdata`  in  8  read byte, valid the cycle after `mem_en & ~mem_we`

## Operation
- States: IDLE, XFER, LAST, ACK.
- IDLE: sample requests. One request is granted. If both request, grant the requester not granted last (round-robin bit `last`). At reset `last` = dbg, so the cpu wins the first tie. On grant, latch we/addr/size/wdata and clear byte counter `k`. Then go to XFER.
- XFER: each cycle `mem_en`=1, `mem_we`=we, `mem_addr`=addr+k, `mem_wdata`=wdata[8k+7:8k]. Byte count n = 1/2/4. After k = n-1, go to LAST for a load or ACK for a store.
- LAST (load only): capture the final byte. Each read byte from cycle k lands in rdata[8k+7:8k] one cycle later.
- ACK: assert the granted requester's ack for exactly one cycle. Update `last`. Return to IDLE.
- Loads: rdata bytes above n are zero. Sign extension is the pipeline's job. rdata holds its value until the next load's first capture.
- Address arithmetic is modulo 2^ADDR_W. Unaligned accesses are legal and performed byte-serially.
- Request fields are latched at grant. Changing or dropping req mid-transfer does not abort the transfer, and ack is still pulsed.
- req still high in the IDLE cycle after ack counts as a new request.
- Reset, async at any point: state IDLE, `last`=dbg, k=0, rdata=0. All outputs deassert immediately. The interrupted transfer gets no ack.

## Timing
- Grant edge = rising edge where IDLE samples req.
- Latency from grant edge to the ack cycle:
  - store byte/half/word: 2 / 3 / 5 cycles
  - load byte/half/word: 3 / 4 / 6 cycles
- Minimum gap between two accesses: one IDLE cycle.
- Reset values: `cpu_ack`=`dbg_ack`=0, `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0. `cpu_stall` follows `cpu_req`.
- The mem_* outputs are registered in XFER. `cpu_stall` is the only combinational output.

## Structure
- Shared package `riscv_pkg`:
  - `mem_size_t` enum (SZ_B, SZ_H, SZ_W)
  - `arb_state_t` enum
  - `function nbytes(mem_size_t)`
- Sub-module `dmem_rr_pick`: two-requester round-robin grant from (cpu_req, dbg_req, last).
- FSM, counter and byte assembly stay in `dmem_arbiter`.

## Test plan
- cpu store word 0x0F0F0F0D @ 4, then cpu load word @ 4:
  - mem bytes 4..7 = 0D 0F 0F 0F
  - store ack 5 cycles after grant
  - load ack 6 cycles after grant, rdata=0x0F0F0F0D
- cpu load half @ 16 with mem[16]=0x11, mem[17]=0xFF -> rdata=0x0000FF11; cpu_stall high from req until the ack cycle.
- cpu and dbg both hold req continuously (byte loads) -> grants alternate cpu, dbg, cpu, dbg; neither waits more than one transfer.
- dbg store word @ 0xFFFFFFFE (ADDR_W=32) -> bytes written at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst low in the 2nd XFER cycle of a word store:
  - mem_en drops immediately
  - only byte 0 written, no ack
  - after release, the first tie goes to cpu
- cpu drops req in the 1st XFER cycle of a byte load -> transfer completes, cpu_ack pulses once, rdata updated.
